// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch unit. Walks the program counter, issues word reads to
//   instruction memory over a req/ack handshake and buffers returned words in
//   a 2-entry queue for decode. Branch/jump targets from execute restart the
//   stream through redirect_valid/redirect_pc.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   redirect_valid one-cycle pulse: flush queue, restart fetch at redirect_pc
//   redirect_pc    restart address (bits [1:0] ignored)
//   imem_req       registered read request to instruction memory
//   imem_addr      registered word-aligned read address
//   imem_ack       memory accepted the request; imem_rdata valid this cycle
//   imem_rdata     returned instruction word
//   out_valid      queue head holds an instruction
//   out_instr      queue head instruction
//   out_pc         address of out_instr
//   out_ready      decode takes the head when out_valid=1
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready
);

    typedef enum logic [1:0] {IDLE, FETCH, STALL, DISCARD} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;    // address of the current / next request
    logic [ADDR_W-1:0] target_pc;   // redirect target held while DISCARD waits
    logic [ADDR_W-1:0] redir_pc;

    entry_t            q_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        count_next;

    logic              acked;
    logic              push;
    logic              pop;

    assign redir_pc = redirect_pc & ALIGN_MASK;
    assign acked    = imem_req & imem_ack;

    // A redirect flushes the queue, so it suppresses both the push of
    // same-cycle ack data and the pop of the old head.
    assign push       = (state == FETCH) & acked & ~redirect_valid;
    assign pop        = (count != 2'd0) & out_ready & ~redirect_valid;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // Head outputs come straight from queue registers.
    assign out_valid = (count != 2'd0);
    assign out_instr = q_mem[rd_ptr].instr;
    assign out_pc    = q_mem[rd_ptr].pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            for (int i = 0; i < 2; i++) q_mem[i] <= '0;
        end else begin
            // ---------------- queue ----------------
            if (redirect_valid) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    q_mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rdata};
                    wr_ptr        <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
                count <= count_next;
            end

            // ---------------- fetch control ----------------
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redirect_valid) begin
                        fetch_pc  <= redir_pc;
                        imem_addr <= redir_pc;
                    end else begin
                        imem_addr <= fetch_pc;
                    end
                end

                FETCH: begin
                    if (imem_req && !imem_ack) begin
                        // Request in flight: it cannot be withdrawn, so a
                        // redirect has to wait for its ack in DISCARD.
                        if (redirect_valid) begin
                            target_pc <= redir_pc;
                            state     <= DISCARD;
                        end
                    end else if (redirect_valid) begin
                        fetch_pc  <= redir_pc;
                        imem_addr <= redir_pc;
                        imem_req  <= 1'b1;
                    end else if (imem_req) begin
                        // Ack: drop req for one cycle, re-issue next cycle
                        // unless the queue is now full.
                        fetch_pc <= fetch_pc + PC_STEP;
                        imem_req <= 1'b0;
                        if (count_next == 2'd2) state <= STALL;
                    end else begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end

                STALL: begin
                    if (redirect_valid) begin
                        state     <= FETCH;
                        fetch_pc  <= redir_pc;
                        imem_addr <= redir_pc;
                        imem_req  <= 1'b1;
                    end else if (count_next < 2'd2) begin
                        state     <= FETCH;
                        imem_addr <= fetch_pc;
                        imem_req  <= 1'b1;
                    end
                end

                DISCARD: begin
                    if (imem_ack) begin
                        // Stale data dropped; a redirect arriving together
                        // with the ack is the newest target.
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        if (redirect_valid) begin
                            fetch_pc  <= redir_pc;
                            imem_addr <= redir_pc;
                        end else begin
                            fetch_pc  <= target_pc;
                            imem_addr <= target_pc;
                        end
                    end else if (redirect_valid) begin
                        target_pc <= redir_pc;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
